// File: rtl/latch_rd_pkg.sv
// -----------------------------------------------------------------------------
// latch_rd_pkg
// Shared types and helpers for the latch snapshot reader.
//   state_e   : reader FSM states
//   cnt_width : width of a counter that must hold the values 0..n
// -----------------------------------------------------------------------------
package latch_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FREEZE,
    SAMPLE1,
    SAMPLE2,
    PRESENT
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/latch_settle_timer.sv
// -----------------------------------------------------------------------------
// latch_settle_timer
// Down-counter that measures the dwell with the latch bank frozen.
// Ports:
//   clk     : system clock
//   rst     : synchronous, active-high reset (counter cleared)
//   load_i  : reload the counter with SETTLE
//   count_i : decrement while high; holds at zero, never wraps
//   done_o  : high in the last cycle of the dwell
// -----------------------------------------------------------------------------
module latch_settle_timer
  import latch_rd_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic count_i,
  output logic done_o
);

  localparam int CNT_W = cnt_width(SETTLE);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(SETTLE);
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with SETTLE on entry, so reaching 1 marks the SETTLE-th cycle.
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/latch_snapshot_reader.sv
// -----------------------------------------------------------------------------
// latch_snapshot_reader
// Freezes a bank of transparent D latches, waits SETTLE cycles, samples the
// bank twice and presents the agreed value on a valid/ready port. After
// MAX_RETRY disagreeing sample pairs the last sample is presented with rd_err.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous, active-high reset; aborts any read in progress
//   latch_q   : latch bank outputs (WIDTH)
//   rd_req    : read request, only honoured in IDLE
//   out_ready : consumer accepts rd_data while rd_valid is high
//   latch_en  : registered latch enable, 1 = transparent, 0 = frozen
//   rd_data   : registered snapshot (WIDTH), held after the handshake
//   rd_valid  : rd_data valid
//   rd_err    : rd_data is not a confirmed stable sample
//   busy      : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module latch_snapshot_reader
  import latch_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] latch_q,
  input  logic             rd_req,
  input  logic             out_ready,
  output logic             latch_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             busy
);

  localparam int RETRY_W = cnt_width(MAX_RETRY);

  state_e             state_q;
  logic               latch_en_q;
  logic               rd_valid_q;
  logic               rd_err_q;
  logic [WIDTH-1:0]   rd_data_q;
  logic [WIDTH-1:0]   s1_q;
  logic [RETRY_W-1:0] retry_q;

  logic settle_done;
  logic samples_match;
  logic last_try;
  logic timer_load;
  logic timer_count;

  assign samples_match = (latch_q == s1_q);
  // This pair is the final attempt when retry count + 1 == MAX_RETRY.
  assign last_try      = (retry_q == RETRY_W'(MAX_RETRY - 1));

  // The dwell restarts on a fresh request and on every retry.
  assign timer_load  = ((state_q == IDLE) && rd_req) ||
                       ((state_q == SAMPLE2) && !samples_match && !last_try);
  assign timer_count = (state_q == FREEZE);

  latch_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (timer_load),
    .count_i (timer_count),
    .done_o  (settle_done)
  );

  // NOTE: s1_q has no reset; it is always written in SAMPLE1 before SAMPLE2
  // reads it, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (state_q == SAMPLE1) begin
      s1_q <= latch_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      latch_en_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
      retry_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            state_q    <= FREEZE;
            latch_en_q <= 1'b0;
            retry_q    <= '0;
          end
        end
        FREEZE: begin
          if (settle_done) begin
            state_q <= SAMPLE1;
          end
        end
        SAMPLE1: begin
          state_q <= SAMPLE2;
        end
        SAMPLE2: begin
          if (samples_match) begin
            rd_data_q  <= s1_q;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b1;
            latch_en_q <= 1'b1;
            state_q    <= PRESENT;
          end else if (last_try) begin
            // Out of retries: hand over the most recent sample, flagged.
            rd_data_q  <= latch_q;
            rd_err_q   <= 1'b1;
            rd_valid_q <= 1'b1;
            latch_en_q <= 1'b1;
            state_q    <= PRESENT;
          end else begin
            retry_q <= retry_q + RETRY_W'(1);
            state_q <= FREEZE;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          latch_en_q <= 1'b1;
          rd_valid_q <= 1'b0;
          rd_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign latch_en = latch_en_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_latch_snapshot_reader.sv
// -----------------------------------------------------------------------------
// tb_latch_snapshot_reader
// Directed scenarios with literal expectations, then randomized traffic. A
// transaction-level model (cycles elapsed since the request, split into
// rounds of SETTLE+2) predicts every output and is compared each cycle.
// -----------------------------------------------------------------------------
module tb_latch_snapshot_reader;

  localparam int WIDTH     = 8;
  localparam int SETTLE    = 2;
  localparam int MAX_RETRY = 3;
  localparam int ROUND     = SETTLE + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] latch_q = '0;
  logic             rd_req = 1'b0;
  logic             out_ready = 1'b0;
  logic             latch_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_err;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  latch_snapshot_reader #(
    .WIDTH     (WIDTH),
    .SETTLE    (SETTLE),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .latch_q   (latch_q),
    .rd_req    (rd_req),
    .out_ready (out_ready),
    .latch_en  (latch_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a read is "active" for some number of elapsed cycles k.
  // Cycle k (k>=1) belongs to attempt (k-1)/ROUND at offset (k-1)%ROUND;
  // offsets 0..SETTLE-1 are the frozen dwell, SETTLE is the first sample,
  // SETTLE+1 the second sample and verdict.
  // ---------------------------------------------------------------------------
  bit               m_armed   = 1'b0;
  bit               m_active  = 1'b0;
  bit               m_present = 1'b0;
  bit               m_err     = 1'b0;
  logic [WIDTH-1:0] m_data    = '0;
  logic [WIDTH-1:0] m_s1      = '0;
  int               m_k       = 0;

  always @(posedge clk) begin
    int ofs, attempt;
    cyc++;
    if (rst) begin
      m_armed   = 1'b1;
      m_active  = 1'b0;
      m_present = 1'b0;
      m_err     = 1'b0;
      m_data    = '0;
    end else if (m_present) begin
      if (out_ready) begin
        m_present = 1'b0;
        m_err     = 1'b0;
      end
    end else if (m_active) begin
      m_k++;
      ofs     = (m_k - 1) % ROUND;
      attempt = (m_k - 1) / ROUND;
      if (ofs == SETTLE) begin
        m_s1 = latch_q;
      end else if (ofs == SETTLE + 1) begin
        if (latch_q == m_s1) begin
          m_active = 1'b0; m_present = 1'b1; m_data = m_s1; m_err = 1'b0;
        end else if (attempt + 1 == MAX_RETRY) begin
          m_active = 1'b0; m_present = 1'b1; m_data = latch_q; m_err = 1'b1;
        end
      end
    end else if (rd_req) begin
      m_active = 1'b1;
      m_k      = 0;
    end
  end

  // Compare process: outputs are registered, so check mid-cycle.
  always @(negedge clk) begin
    if (m_armed) begin
      check("model_cmp {en,valid,err,busy,data}",
            {20'd0, latch_en, rd_valid, rd_err, busy, rd_data},
            {20'd0, ~m_active, m_present, m_err, m_active | m_present, m_data});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic en, input logic v,
                            input logic e, input logic b, input logic [WIDTH-1:0] d);
    check(name, {20'd0, latch_en, rd_valid, rd_err, busy, rd_data},
                {20'd0, en, v, e, b, d});
  endtask

  initial begin
    // 1. Reset with random inputs.
    latch_q   = WIDTH'($urandom);
    rd_req    = 1'($urandom);
    out_ready = 1'($urandom);
    repeat (2) begin
      step();
      latch_q   = WIDTH'($urandom);
      rd_req    = 1'($urandom);
      out_ready = 1'($urandom);
    end
    expect_out("reset_state", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0; rd_req = 1'b0;
    step();

    // 2. Clean read.
    latch_q = 8'hA5; out_ready = 1'b1; rd_req = 1'b1;
    step(); rd_req = 1'b0;
    expect_out("clean_c1_frozen", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) step();
    expect_out("clean_c4_frozen", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    expect_out("clean_c5_valid", 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
    step();
    expect_out("clean_c6_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);

    // 3. Backpressure, latch changes and ignored requests while presenting.
    out_ready = 1'b0; rd_req = 1'b1; latch_q = 8'hA5;
    step(); rd_req = 1'b0;
    repeat (4) step();
    expect_out("bp_c5_valid", 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 10; i++) begin
      latch_q = 8'h3C;
      rd_req  = 1'(i % 2);
      step();
      expect_out("bp_hold", 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
    end
    rd_req = 1'b0; out_ready = 1'b1;
    step();
    expect_out("bp_release", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);

    // 4. Single mismatch, one retry.
    latch_q = 8'hA5; rd_req = 1'b1;
    step(); rd_req = 1'b0;
    repeat (2) step();
    latch_q = 8'hA5;
    step();
    latch_q = 8'h5A;
    repeat (4) step();
    expect_out("retry1_c8_frozen", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    step();
    expect_out("retry1_c9_valid", 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A);
    step();

    // 5. Persistent mismatch: latch_q = 0x10 + cycle index.
    latch_q = 8'h10; rd_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(); rd_req = 1'b0;
      latch_q = 8'h10 + WIDTH'(k);
    end
    step();
    expect_out("err_c13_valid", 1'b1, 1'b1, 1'b1, 1'b1, 8'h1C);
    step();
    expect_out("err_c14_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'h1C);

    // 6. Reset during the dwell aborts the read.
    latch_q = 8'h66; rd_req = 1'b1;
    step(); rd_req = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    expect_out("abort_c3", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (8) step();
    expect_out("abort_no_valid", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rd_req = 1'b1;
    step(); rd_req = 1'b0;
    repeat (4) step();
    expect_out("after_abort_c5", 1'b1, 1'b1, 1'b0, 1'b1, 8'h66);
    step();

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      rd_req    = ($urandom_range(0, 2) == 0);
      out_ready = 1'($urandom);
      if ($urandom_range(0, 3) == 0) latch_q = WIDTH'($urandom);
      step();
    end
    rst = 1'b0; rd_req = 1'b0; out_ready = 1'b1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_snapshot_reader.md
Name: latch_snapshot_reader

Overview:
Clocked reader for a bank of enable-controlled transparent D latches. The bank is written by an external source while its enable is high.
- On request, the block drives the latch enable low to freeze the bank and waits a settle interval.
- It then samples the latch outputs twice and checks that both samples agree.
- It presents the result on a valid/ready output port, then re-opens the latches.
- It sits between the latch bank (writer side) and synchronous consumer logic.

Parameters:
WIDTH, 8, bit width of latch bank and read data
SETTLE, 2, cycles latch_en is held low before first sample (>=1)
MAX_RETRY, 3, mismatching sample pairs tolerated before reporting an error (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
latch_q  input  WIDTH  outputs of the latch bank being read
rd_req  input  1  read request, sampled only in IDLE
out_ready  input  1  consumer accepts rd_data when high with rd_valid
latch_en  output  1  registered enable to the latch bank; 1=transparent, 0=frozen
rd_data  output  WIDTH  registered snapshot
rd_valid  output  1  rd_data valid
rd_err  output  1  qualifies rd_data: 1 = stable sample not obtained within MAX_RETRY
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, latch_en=1, rd_valid=0, rd_err=0, rd_data=0, busy=0, settle and retry counters=0.
  - Reset has priority over every other event, including mid-operation; operation aborts and no rd_valid is produced.
- IDLE: latch_en=1. If rd_req=1, go to FREEZE next edge with latch_en<=0, settle count=0, retry count=0.
- FREEZE: latch_en=0. Lasts exactly SETTLE cycles, then go to SAMPLE1.
- SAMPLE1: latch_en=0. Capture latch_q into internal s1. Go to SAMPLE2.
- SAMPLE2: latch_en=0. Compare latch_q with s1.
  - Equal: rd_data<=s1, rd_err<=0, rd_valid<=1, latch_en<=1, go to PRESENT.
  - Unequal and retry count+1 < MAX_RETRY: increment retry count, clear settle count, go to FREEZE; latch_en stays 0.
  - Unequal and retry count+1 == MAX_RETRY: rd_data<=latch_q (current sample), rd_err<=1, rd_valid<=1, latch_en<=1, go to PRESENT.
- PRESENT: rd_valid=1, latch_en=1; rd_data and rd_err held stable.
  - When out_ready=1, go to IDLE; rd_valid and rd_err clear on the next edge.
  - rd_data retains its last value after the handshake.
- Latency, counted from the cycle rd_req=1 is seen in IDLE (cycle 0):
  - latch_en low from cycle 1.
  - rd_valid high at cycle SETTLE+3 on a clean read.
  - Each retry adds SETTLE+2 cycles.
- rd_req is ignored outside IDLE; requests are not queued. After a handshake there is at least one IDLE cycle before the next FREEZE.
- latch_q changes while in PRESENT or IDLE have no effect on rd_data.
- Settle counter width is clog2(SETTLE+1); retry counter width is clog2(MAX_RETRY+1). Neither counter wraps.

Decomposition:
- Package latch_rd_pkg: state enum {IDLE, FREEZE, SAMPLE1, SAMPLE2, PRESENT}.
- One natural sub-module, latch_settle_timer: load/count/done down-counter parameterised by SETTLE, used for the FREEZE dwell.
- The comparator and datapath registers stay in the top module.

Test Plan:
Setup for all scenarios: WIDTH=8, SETTLE=2, MAX_RETRY=3.
1. rst=1 for 2 cycles with random inputs -> latch_en=1, rd_valid=0, rd_err=0, rd_data=8'h00, busy=0.
2. Clean read: latch_q=8'hA5 stable, rd_req pulsed at cycle 0, out_ready=1 -> latch_en=0 during cycles 1-4; rd_valid=1, rd_data=8'hA5, rd_err=0, latch_en=1 at cycle 5; rd_valid=0 at cycle 6.
3. Backpressure: same as 2 but out_ready=0 for 10 cycles, and latch_q changes to 8'h3C during PRESENT -> rd_data stays 8'hA5 with rd_valid=1; rd_req pulses are ignored; out_ready=1 -> rd_valid=0 on the next cycle.
4. Single mismatch: latch_q=8'hA5 at SAMPLE1 and 8'h5A at SAMPLE2, then stable 8'h5A -> one retry; rd_valid at cycle 9 with rd_data=8'h5A, rd_err=0.
5. Persistent mismatch: latch_q increments every cycle -> three mismatches; rd_valid=1, rd_err=1 at cycle 13; rd_data equals latch_q sampled in the final SAMPLE2 cycle.
6. rst asserted during FREEZE (cycle 2) -> next cycle latch_en=1, busy=0; no rd_valid is ever produced; a subsequent rd_req completes a clean read with normal timing.
